seed_random_2_card_dealer: RTL and testbench



---
 rtl/seed_random_2_pkg.sv | 16 +
 rtl/seed_random_2_card_decode.sv | 43 ++++
 rtl/seed_random_2_card_dealer.sv | 150 +++++++++++++++
 tb/tb_seed_random_2_card_dealer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_random_2_pkg.sv
// rtl/seed_random_2_pkg.sv - shared deck constants and dealer state encoding
package seed_random_2_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  localparam logic [5:0] LAST_SLOT  = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_COUNT = 6'(DECK_SIZE);
  localparam logic [3:0] FACE_VALUE = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } dealer_state_e;

endpackage

// File: rtl/seed_random_2_card_decode.sv
// rtl/seed_random_2_card_decode.sv - slot index to suit, rank and blackjack value
module seed_random_2_card_decode
  import seed_random_2_pkg::*;
#(
  parameter int unsigned ACE_VALUE = 11
) (
  input  logic [5:0] idx,
  output logic [1:0] suit,
  output logic [3:0] rank,
  output logic [3:0] value
);

  logic [3:0] offset;

  // Divide by 13 with three compares; offset is the position inside the suit.
  always_comb begin
    suit   = 2'd0;
    offset = idx[3:0];
    if (idx >= 6'(3 * RANKS)) begin
      suit   = 2'd3;
      offset = 4'(idx - 6'(3 * RANKS));
    end else if (idx >= 6'(2 * RANKS)) begin
      suit   = 2'd2;
      offset = 4'(idx - 6'(2 * RANKS));
    end else if (idx >= 6'(RANKS)) begin
      suit   = 2'd1;
      offset = 4'(idx - 6'(RANKS));
    end
  end

  // Rank is one-based; aces use the configured value, courts count as ten.
  always_comb begin
    rank = offset + 4'd1;
    if (rank == 4'd1) begin
      value = 4'(ACE_VALUE);
    end else if (rank >= 4'd11) begin
      value = FACE_VALUE;
    end else begin
      value = rank;
    end
  end

endmodule

// File: rtl/seed_random_2_card_dealer.sv
// rtl/seed_random_2_card_dealer.sv - unique-card dealer fed by the free-running random byte counter
module seed_random_2_card_dealer
  import seed_random_2_pkg::*;
#(
  parameter int          RND_W     = 8,
  parameter int unsigned ACE_VALUE = 11
) (
  input  logic             clk_cd_i,
  input  logic             rst_cd_i,
  input  logic             deal_req_i,
  input  logic             shuffle_i,
  input  logic [RND_W-1:0] rnd_byte_i,
  output logic             cnt_run_o,
  output logic             busy_o,
  output logic             card_valid_o,
  output logic [5:0]       card_idx_o,
  output logic [1:0]       card_suit_o,
  output logic [3:0]       card_rank_o,
  output logic [3:0]       card_value_o,
  output logic [5:0]       cards_left_o,
  output logic             deck_empty_o
);

  dealer_state_e        state_q, state_d;
  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [5:0]           probe_idx_q, probe_idx_d;
  logic [5:0]           cards_left_q, cards_left_d;
  logic                 card_valid_q, card_valid_d;
  logic [5:0]           card_idx_q, card_idx_d;
  logic [1:0]           card_suit_q, card_suit_d;
  logic [3:0]           card_rank_q, card_rank_d;
  logic [3:0]           card_value_q, card_value_d;

  logic [5:0]           start_slot;
  logic [1:0]           dec_suit;
  logic [3:0]           dec_rank;
  logic [3:0]           dec_value;

  // The reducer only works for an 8-bit byte: at most four subtractions of 52.
  always_comb begin
    if (rnd_byte_i >= 8'd208) begin
      start_slot = 6'(rnd_byte_i - 8'd208);
    end else if (rnd_byte_i >= 8'd156) begin
      start_slot = 6'(rnd_byte_i - 8'd156);
    end else if (rnd_byte_i >= 8'd104) begin
      start_slot = 6'(rnd_byte_i - 8'd104);
    end else if (rnd_byte_i >= 8'd52) begin
      start_slot = 6'(rnd_byte_i - 8'd52);
    end else begin
      start_slot = 6'(rnd_byte_i);
    end
  end

  // Decode the slot under the probe so the result is ready to register on a hit.
  seed_random_2_card_decode #(
    .ACE_VALUE (ACE_VALUE)
  ) u_decode (
    .idx   (probe_idx_q),
    .suit  (dec_suit),
    .rank  (dec_rank),
    .value (dec_value)
  );

  // Next-state logic: shuffle overrides everything; a probe walks forward until a free slot.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    probe_idx_d  = probe_idx_q;
    cards_left_d = cards_left_q;
    card_valid_d = 1'b0;
    card_idx_d   = card_idx_q;
    card_suit_d  = card_suit_q;
    card_rank_d  = card_rank_q;
    card_value_d = card_value_q;

    if (shuffle_i) begin
      mask_d       = '0;
      cards_left_d = FULL_COUNT;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (deal_req_i && (cards_left_q != 6'd0)) begin
            probe_idx_d = start_slot;
            state_d     = PROBE;
          end
        end
        PROBE: begin
          if (mask_q[probe_idx_q]) begin
            probe_idx_d = (probe_idx_q == LAST_SLOT) ? 6'd0 : probe_idx_q + 6'd1;
          end else begin
            mask_d[probe_idx_q] = 1'b1;
            cards_left_d        = cards_left_q - 6'd1;
            card_valid_d        = 1'b1;
            card_idx_d          = probe_idx_q;
            card_suit_d         = dec_suit;
            card_rank_d         = dec_rank;
            card_value_d        = dec_value;
            state_d             = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_cd_i or negedge rst_cd_i) begin
    if (!rst_cd_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Deck mask, probe pointer and registered card outputs.
  always_ff @(posedge clk_cd_i or negedge rst_cd_i) begin
    if (!rst_cd_i) begin
      mask_q       <= '0;
      probe_idx_q  <= 6'd0;
      cards_left_q <= FULL_COUNT;
      card_valid_q <= 1'b0;
      card_idx_q   <= 6'd0;
      card_suit_q  <= 2'd0;
      card_rank_q  <= 4'd0;
      card_value_q <= 4'd0;
    end else begin
      mask_q       <= mask_d;
      probe_idx_q  <= probe_idx_d;
      cards_left_q <= cards_left_d;
      card_valid_q <= card_valid_d;
      card_idx_q   <= card_idx_d;
      card_suit_q  <= card_suit_d;
      card_rank_q  <= card_rank_d;
      card_value_q <= card_value_d;
    end
  end

  // The counter runs only while idle, so the sampled byte is frozen during a deal.
  assign cnt_run_o    = (state_q == IDLE);
  assign busy_o       = (state_q == PROBE);
  assign card_valid_o = card_valid_q;
  assign card_idx_o   = card_idx_q;
  assign card_suit_o  = card_suit_q;
  assign card_rank_o  = card_rank_q;
  assign card_value_o = card_value_q;
  assign cards_left_o = cards_left_q;
  assign deck_empty_o = (cards_left_q == 6'd0);

endmodule

// File: tb/tb_seed_random_2_card_dealer.sv
// tb/tb_seed_random_2_card_dealer.sv - self-checking bench for the card dealer
module tb_seed_random_2_card_dealer;

  logic       clk_cd_i = 1'b0;
  logic       rst_cd_i = 1'b0;
  logic       deal_req_i = 1'b0;
  logic       shuffle_i = 1'b0;
  logic [7:0] rnd_byte_i = 8'd0;
  logic       cnt_run_o, busy_o, card_valid_o, deck_empty_o;
  logic [5:0] card_idx_o, cards_left_o;
  logic [1:0] card_suit_o;
  logic [3:0] card_rank_o, card_value_o;

  int total = 0;
  int bad = 0;

  // Reference deck: which slots are gone and how many remain.
  bit model_dealt [52];
  int model_left;

  typedef struct {
    bit         do_shuffle;
    logic [7:0] rnd;
    int         idx, suit, rank, value, lat, left;
  } vec_t;

  vec_t vecs [11];

  seed_random_2_card_dealer #(.RND_W(8), .ACE_VALUE(11)) dut (
    .clk_cd_i     (clk_cd_i),
    .rst_cd_i     (rst_cd_i),
    .deal_req_i   (deal_req_i),
    .shuffle_i    (shuffle_i),
    .rnd_byte_i   (rnd_byte_i),
    .cnt_run_o    (cnt_run_o),
    .busy_o       (busy_o),
    .card_valid_o (card_valid_o),
    .card_idx_o   (card_idx_o),
    .card_suit_o  (card_suit_o),
    .card_rank_o  (card_rank_o),
    .card_value_o (card_value_o),
    .cards_left_o (cards_left_o),
    .deck_empty_o (deck_empty_o)
  );

  always #5 clk_cd_i = ~clk_cd_i;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cd_i);
    #1;
  endtask

  function automatic int value_of(input int rank);
    if (rank == 1) return 11;
    if (rank > 10) return 10;
    return rank;
  endfunction

  task automatic model_clear();
    foreach (model_dealt[i]) model_dealt[i] = 1'b0;
    model_left = 52;
  endtask

  // Expected outcome of one deal: first free slot at or after byte mod 52.
  task automatic model_deal(input logic [7:0] b, output int idx, output int lat);
    int s;
    s = int'(b) % 52;
    lat = 1;
    while (model_dealt[s]) begin
      s = (s + 1) % 52;
      lat++;
    end
    model_dealt[s] = 1'b1;
    model_left--;
    idx = s;
  endtask

  task automatic do_shuffle();
    shuffle_i = 1'b1;
    tick();
    shuffle_i = 1'b0;
  endtask

  // Issue one request from an idle cycle and check the returned card.
  task automatic run_deal(input logic [7:0] b, input int e_idx, input int e_suit,
                          input int e_rank, input int e_value, input int e_lat,
                          input int e_left);
    int lat;
    deal_req_i = 1'b1;
    rnd_byte_i = b;
    tick();
    deal_req_i = 1'b0;
    chk("accept_busy", busy_o, 1);
    chk("accept_cnt_run", cnt_run_o, 0);
    lat = 0;
    while (!card_valid_o && lat < 60) begin
      tick();
      lat++;
    end
    chk("deal_latency", lat, e_lat);
    chk("card_idx", card_idx_o, e_idx);
    chk("card_suit", card_suit_o, e_suit);
    chk("card_rank", card_rank_o, e_rank);
    chk("card_value", card_value_o, e_value);
    chk("cards_left", cards_left_o, e_left);
    chk("done_busy", busy_o, 0);
    chk("done_cnt_run", cnt_run_o, 1);
  endtask

  task automatic model_run_deal(input logic [7:0] b);
    int idx, lat;
    model_deal(b, idx, lat);
    run_deal(b, idx, idx / 13, idx % 13 + 1, value_of(idx % 13 + 1), lat, model_left);
  endtask

  // Leave exactly one free slot, then start a worst-case 51-skip probe.
  task automatic start_long_probe(output int last_idx);
    int free_slot, lat;
    logic [7:0] b;
    do_shuffle();
    model_clear();
    last_idx = 0;
    for (int i = 0; i < 51; i++) begin
      b = 8'($urandom_range(0, 255));
      model_deal(b, last_idx, lat);
      run_deal(b, last_idx, last_idx / 13, last_idx % 13 + 1,
               value_of(last_idx % 13 + 1), lat, model_left);
    end
    free_slot = 0;
    for (int s = 0; s < 52; s++) if (!model_dealt[s]) free_slot = s;
    b = 8'((free_slot + 1) % 52 + 52 * $urandom_range(0, 3));
    deal_req_i = 1'b1;
    rnd_byte_i = b;
    tick();
    deal_req_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("long_probe_busy", busy_o, 1);
  endtask

  initial begin
    int last_idx, pulses, uniq;
    bit seen [52];

    vecs[0]  = '{1'b0, 8'hFF, 47, 3, 9, 9, 1, 51};
    vecs[1]  = '{1'b0, 8'h00, 0, 0, 1, 11, 1, 50};
    vecs[2]  = '{1'b1, 8'h05, 5, 0, 6, 6, 1, 51};
    vecs[3]  = '{1'b0, 8'h05, 6, 0, 7, 7, 2, 50};
    vecs[4]  = '{1'b1, 8'h33, 51, 3, 13, 10, 1, 51};
    vecs[5]  = '{1'b0, 8'h00, 0, 0, 1, 11, 1, 50};
    vecs[6]  = '{1'b0, 8'h33, 1, 0, 2, 2, 3, 49};
    vecs[7]  = '{1'b1, 8'hD0, 0, 0, 1, 11, 1, 51};
    vecs[8]  = '{1'b0, 8'hCF, 51, 3, 13, 10, 1, 50};
    vecs[9]  = '{1'b0, 8'h34, 1, 0, 2, 2, 2, 49};
    vecs[10] = '{1'b0, 8'h33, 2, 0, 3, 3, 4, 48};

    // Reset state.
    repeat (3) @(posedge clk_cd_i);
    #1 rst_cd_i = 1'b1;
    tick();
    chk("rst_cnt_run", cnt_run_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", card_valid_o, 0);
    chk("rst_idx", card_idx_o, 0);
    chk("rst_suit", card_suit_o, 0);
    chk("rst_rank", card_rank_o, 0);
    chk("rst_value", card_value_o, 0);
    chk("rst_left", cards_left_o, 52);
    chk("rst_empty", deck_empty_o, 0);

    // Directed vectors: basic deals, collision, wrap and reducer boundaries.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_shuffle) do_shuffle();
      run_deal(vecs[i].rnd, vecs[i].idx, vecs[i].suit, vecs[i].rank,
               vecs[i].value, vecs[i].lat, vecs[i].left);
      tick();
      chk("valid_one_cycle", card_valid_o, 0);
    end

    // Back-to-back: request held through the card_valid cycle.
    do_shuffle();
    deal_req_i = 1'b1;
    rnd_byte_i = 8'h0A;
    tick();
    chk("b2b_busy_first", busy_o, 1);
    tick();
    chk("b2b_valid_first", card_valid_o, 1);
    chk("b2b_idx_first", card_idx_o, 10);
    tick();
    deal_req_i = 1'b0;
    chk("b2b_busy_second", busy_o, 1);
    chk("b2b_valid_gap", card_valid_o, 0);
    tick();
    chk("b2b_probe_skip", card_valid_o, 0);
    tick();
    chk("b2b_valid_second", card_valid_o, 1);
    chk("b2b_idx_second", card_idx_o, 11);
    chk("b2b_left", cards_left_o, 50);

    // Exhaustion with random bytes against the model.
    do_shuffle();
    model_clear();
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 52; i++) begin
      model_run_deal(8'($urandom_range(0, 255)));
      if (card_idx_o < 52) seen[card_idx_o] = 1'b1;
    end
    uniq = 0;
    foreach (seen[i]) if (seen[i]) uniq++;
    chk("distinct_cards", uniq, 52);
    chk("exhaust_left", cards_left_o, 0);
    chk("exhaust_empty", deck_empty_o, 1);
    deal_req_i = 1'b1;
    rnd_byte_i = 8'($urandom_range(0, 255));
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (card_valid_o || busy_o || !cnt_run_o) pulses++;
    end
    deal_req_i = 1'b0;
    chk("empty_req_ignored", pulses, 0);
    chk("empty_cnt_run", cnt_run_o, 1);
    do_shuffle();
    chk("reshuffle_left", cards_left_o, 52);
    chk("reshuffle_empty", deck_empty_o, 0);

    // Abort by shuffle during a long probe.
    start_long_probe(last_idx);
    shuffle_i = 1'b1;
    tick();
    shuffle_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (card_valid_o) pulses++;
      tick();
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_cnt_run", cnt_run_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_left", cards_left_o, 52);
    chk("abort_idx_held", card_idx_o, last_idx);

    // Abort by asynchronous reset during a long probe.
    start_long_probe(last_idx);
    #2 rst_cd_i = 1'b0;
    #1;
    chk("mid_rst_cnt_run", cnt_run_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", card_valid_o, 0);
    chk("mid_rst_idx", card_idx_o, 0);
    chk("mid_rst_rank", card_rank_o, 0);
    chk("mid_rst_value", card_value_o, 0);
    chk("mid_rst_suit", card_suit_o, 0);
    chk("mid_rst_left", cards_left_o, 52);
    tick();
    rst_cd_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (card_valid_o || busy_o) pulses++;
    end
    chk("post_rst_quiet", pulses, 0);
    chk("post_rst_left", cards_left_o, 52);
    chk("post_rst_empty", deck_empty_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
